// File: rtl/rs232_rx_ctrl.sv
// rs232_rx_ctrl: 8N1 serial receiver with mid-bit oversampling, val/rdy byte output, frame-error and overrun pulses.
module rs232_rx_ctrl #(
  parameter int BAUD = 9600,
  parameter int CLKMUL = 1,
  parameter int CLKDIV = 1,
  parameter int CLKIN_PERIOD = 10,
  parameter int CLOCKS_PER_BIT = int'(64'd1_000_000_000 * CLKMUL / (BAUD * CLKDIV * CLKIN_PERIOD))
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic       val,
  input  logic       rdy,
  output logic [7:0] bits,
  output logic       frame_err,
  output logic       overrun
);
  localparam int W = $clog2(CLOCKS_PER_BIT);
  localparam logic [W-1:0] C_M1 = W'(CLOCKS_PER_BIT - 1);
  localparam logic [W-1:0] H_M1 = W'(CLOCKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d, bits_q, bits_d;
  logic val_q, val_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic rxs, deliver;
  assign rxs = sync_q[1];
  always_comb begin
    sync_d = {sync_q[0], RxD};
    state_d = state_q;
    cnt_d = cnt_q + W'(1);
    idx_d = idx_q;
    sh_d = sh_q;
    deliver = 1'b0;
    frame_err_d = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rxs ? IDLE : START;
      end
      START: if (cnt_q == H_M1) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (cnt_q == C_M1) begin
        cnt_d = '0;
        sh_d = {rxs, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == C_M1) begin
        cnt_d = '0;
        deliver = rxs;
        frame_err_d = !rxs;
        state_d = rxs ? IDLE : BRK;
      end
      BRK: begin
        cnt_d = '0;
        state_d = rxs ? IDLE : BRK;
      end
      default: state_d = IDLE;
    endcase
    // a delivery in the same cycle as a handshake reloads instead of clearing
    val_d = val_q && !rdy;
    bits_d = bits_q;
    if (deliver && (!val_q || rdy)) begin
      val_d = 1'b1;
      bits_d = sh_q;
    end
    overrun_d = deliver && val_q && !rdy;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      bits_q <= '0;
      val_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      bits_q <= bits_d;
      val_q <= val_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  assign val = val_q;
  assign bits = bits_q;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
endmodule
